// File: rtl/pal_sync_generator.sv
// Free-running PAL 576i composite sync generator: line/sample counters plus
// registered decode of csync, hsync, vsync and field (one clock behind the counters).
module pal_sync_generator #(
  parameter int LINE_CLKS  = 5184,
  parameter int HSYNC_CLKS = 381,
  parameter int EQ_CLKS    = 190,
  parameter int BROAD_CLKS = 2211
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resync,
  output logic        csync,
  output logic        hsync,
  output logic        vsync,
  output logic        field,
  output logic [9:0]  line_num,
  output logic [12:0] h_count
);

  localparam logic [12:0] H_LAST  = 13'(LINE_CLKS - 1);
  localparam logic [12:0] H_HALF  = 13'(LINE_CLKS / 2);
  localparam logic [12:0] H_SYNC  = 13'(HSYNC_CLKS);
  localparam logic [12:0] H_EQ    = 13'(EQ_CLKS);
  localparam logic [12:0] H_BROAD = 13'(BROAD_CLKS);

  typedef enum logic [1:0] {SLOT_NONE, SLOT_LINE, SLOT_EQ, SLOT_BROAD} slot_t;

  slot_t       slot_a, slot_b, slot_cur;
  logic        second_half;
  logic [12:0] offset;
  logic        csync_next, vsync_next;

  always_ff @(posedge clk) begin
    if (reset || resync) begin
      line_num <= 10'd1;
      h_count  <= 13'd0;
    end else if (h_count == H_LAST) begin
      h_count  <= 13'd0;
      line_num <= (line_num == 10'd625) ? 10'd1 : line_num + 10'd1;
    end else begin
      h_count <= h_count + 13'd1;
    end
  end

  // Half-line slot types; lines not matched below are E/E.
  always_comb begin
    slot_a = SLOT_EQ;
    slot_b = SLOT_EQ;
    if (line_num <= 10'd2) begin
      slot_a = SLOT_BROAD;
      slot_b = SLOT_BROAD;
    end else if (line_num == 10'd3) begin
      slot_a = SLOT_BROAD;
    end else if (line_num <= 10'd5) begin
      slot_a = SLOT_EQ;
    end else if (line_num <= 10'd310) begin
      slot_a = SLOT_LINE;
      slot_b = SLOT_NONE;
    end else if (line_num <= 10'd312) begin
      slot_a = SLOT_EQ;
    end else if (line_num == 10'd313) begin
      slot_b = SLOT_BROAD;
    end else if (line_num <= 10'd315) begin
      slot_a = SLOT_BROAD;
      slot_b = SLOT_BROAD;
    end else if (line_num <= 10'd317) begin
      slot_a = SLOT_EQ;
    end else if (line_num == 10'd318) begin
      slot_b = SLOT_NONE;
    end else if (line_num <= 10'd622) begin
      slot_a = SLOT_LINE;
      slot_b = SLOT_NONE;
    end else if (line_num == 10'd623) begin
      slot_a = SLOT_LINE;
    end

    second_half = (h_count >= H_HALF);
    offset      = second_half ? (h_count - H_HALF) : h_count;
    slot_cur    = second_half ? slot_b : slot_a;

    case (slot_cur)
      SLOT_LINE:  csync_next = (offset >= H_SYNC);
      SLOT_EQ:    csync_next = (offset >= H_EQ);
      SLOT_BROAD: csync_next = (offset >= H_BROAD);
      default:    csync_next = 1'b1;
    endcase

    vsync_next = (line_num <= 10'd2) ||
                 (line_num == 10'd3 && !second_half) ||
                 (line_num == 10'd313 && second_half) ||
                 (line_num == 10'd314) || (line_num == 10'd315);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csync <= 1'b1;
      hsync <= 1'b0;
      vsync <= 1'b0;
      field <= 1'b0;
    end else begin
      csync <= csync_next;
      hsync <= (h_count == 13'd0);
      vsync <= vsync_next;
      field <= (line_num >= 10'd313);
    end
  end

endmodule

// File: tb/tb_pal_sync_generator.sv
// Randomized bench for pal_sync_generator with shortened lines so a whole frame
// fits; expected outputs come from a frame-position model of the sync pattern.
module tb_pal_sync_generator;

  localparam int LINE  = 64;
  localparam int HALF  = LINE / 2;
  localparam int HSYN  = 5;
  localparam int EQ    = 3;
  localparam int BROAD = HALF - HSYN;
  localparam int FRAME = 625 * LINE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resync = 1'b0;
  logic        csync, hsync, vsync, field;
  logic [9:0]  line_num;
  logic [12:0] h_count;

  int n_checks = 0;
  int n_errors = 0;

  int         pos = 0;
  logic [3:0] exp_dec = 4'b1000;
  longint     cycle = 0;
  bit         counting = 0;
  int         hs_count = 0, vs_count = 0, bad_spacing = 0;
  longint     last_hs = -1;

  pal_sync_generator #(
    .LINE_CLKS(LINE), .HSYNC_CLKS(HSYN), .EQ_CLKS(EQ), .BROAD_CLKS(BROAD)
  ) dut (
    .clk(clk), .reset(reset), .resync(resync),
    .csync(csync), .hsync(hsync), .vsync(vsync), .field(field),
    .line_num(line_num), .h_count(h_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Slot type per line: 0 none, 1 line sync, 2 equalising, 3 broad.
  function automatic int slot_type(int line, bit b);
    if (line <= 2)   return 3;
    if (line == 3)   return b ? 2 : 3;
    if (line <= 5)   return 2;
    if (line <= 310) return b ? 0 : 1;
    if (line <= 312) return 2;
    if (line == 313) return b ? 3 : 2;
    if (line <= 315) return 3;
    if (line <= 317) return 2;
    if (line == 318) return b ? 0 : 2;
    if (line <= 622) return b ? 0 : 1;
    if (line == 623) return b ? 2 : 1;
    return 2;
  endfunction

  // {csync, hsync, vsync, field} for a frame position.
  function automatic logic [3:0] decode(int p);
    int  line = p / LINE + 1;
    int  h = p % LINE;
    bit  b = (h >= HALF);
    int  off = b ? h - HALF : h;
    bit  cs, vs;
    case (slot_type(line, b))
      1: cs = (off >= HSYN);
      2: cs = (off >= EQ);
      3: cs = (off >= BROAD);
      default: cs = 1'b1;
    endcase
    vs = (p < 2 * LINE + HALF) || (p >= 312 * LINE + HALF && p < 315 * LINE);
    return {cs, (h == 0), vs, (line >= 313)};
  endfunction

  task automatic step();
    logic [31:0] got, exp;
    @(posedge clk);
    if (reset) begin
      exp_dec = 4'b1000;
      pos = 0;
    end else begin
      exp_dec = decode(pos);
      pos = resync ? 0 : (pos + 1) % FRAME;
    end
    cycle++;
    #1;
    got = {5'b0, csync, hsync, vsync, field, line_num, h_count};
    exp = {5'b0, exp_dec, 10'(pos / LINE + 1), 13'(pos % LINE)};
    check("outputs", got, exp);
    if (counting) begin
      if (hsync === 1'b1) begin
        hs_count++;
        if (last_hs >= 0 && cycle - last_hs != LINE) bad_spacing++;
        last_hs = cycle;
      end
      if (vsync === 1'b1) vs_count++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    step();
    resync = 1'b0;
  endtask

  initial begin
    run(3);
    reset = 1'b0;

    counting = 1;
    run(FRAME);
    counting = 0;
    check("hsync_per_frame", 32'(hs_count), 32'd625);
    check("hsync_spacing_errs", 32'(bad_spacing), 32'd0);
    check("vsync_clks_per_frame", 32'(vs_count), 32'(10 * HALF));

    for (int k = 0; k < 25; k++) begin
      run($urandom_range(0, 3 * LINE));
      if ($urandom_range(0, 2) == 0) pulse_resync();
    end

    // Resync coinciding with a line wrap.
    for (int g = 0; g < 2 * LINE && pos % LINE != LINE - 1; g++) step();
    pulse_resync();
    run(LINE + 3);

    // Reset in the middle of a broad pulse on line 314, with resync also high.
    pulse_resync();
    run(313 * LINE + 5 - 1);
    reset = 1'b1;
    resync = 1'b1;
    step();
    resync = 1'b0;
    step();
    reset = 1'b0;
    run(3 * LINE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
